// File: rtl/exu_div_if.sv
// exu_div_if: issue bundle, flush, busy and writeback handshake; master = pipeline side, slave = divider
interface exu_div_if #(
  parameter int XLEN = 32,
  parameter int TAG_W = 4
);
  logic flush;
  logic div_valid;
  logic div_rem;
  logic div_unsign;
  logic [XLEN-1:0] div_rs1;
  logic [XLEN-1:0] div_rs2;
  logic [4:0] div_rd_addr;
  logic [TAG_W-1:0] div_tag;
  logic div_busy;
  logic wb_valid;
  logic wb_ready;
  logic [XLEN-1:0] wb_data;
  logic [4:0] wb_rd_addr;
  logic [TAG_W-1:0] wb_tag;
  modport master (
    output flush, div_valid, div_rem, div_unsign, div_rs1, div_rs2, div_rd_addr, div_tag, wb_ready,
    input div_busy, wb_valid, wb_data, wb_rd_addr, wb_tag
  );
  modport slave (
    input flush, div_valid, div_rem, div_unsign, div_rs1, div_rs2, div_rd_addr, div_tag, wb_ready,
    output div_busy, wb_valid, wb_data, wb_rd_addr, wb_tag
  );
endinterface

// File: rtl/exu_div.sv
// exu_div: iterative radix-2 restoring RV32M divider; clk/rst plain, issue/busy/flush/writeback via exu_div_if.slave
module exu_div #(
  parameter int XLEN = 32,
  parameter int TAG_W = 4
) (
  input logic clk,
  input logic rst,
  exu_div_if.slave d
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_MAX = CW'(XLEN - 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] quot, rem_q, dvs, wb_data;
  logic [4:0] wb_rd_addr;
  logic [TAG_W-1:0] wb_tag;
  logic op_rem, q_neg, r_neg;
  logic s1, s2, dz, ovf, ge;
  logic [XLEN-1:0] a1, a2, sub, q_fix, r_fix;
  logic [XLEN:0] r_sh;
  assign s1 = !d.div_unsign && d.div_rs1[XLEN-1];
  assign s2 = !d.div_unsign && d.div_rs2[XLEN-1];
  assign a1 = s1 ? -d.div_rs1 : d.div_rs1;
  assign a2 = s2 ? -d.div_rs2 : d.div_rs2;
  assign dz = d.div_rs2 == '0;
  assign ovf = !d.div_unsign && d.div_rs1 == {1'b1, {(XLEN-1){1'b0}}} && d.div_rs2 == '1;
  assign r_sh = {rem_q, quot[XLEN-1]};
  assign ge = r_sh >= {1'b0, dvs};
  assign sub = r_sh[XLEN-1:0] - dvs;
  assign q_fix = q_neg ? -quot : quot;
  assign r_fix = r_neg ? -rem_q : rem_q;
  assign d.div_busy = state != IDLE;
  assign d.wb_valid = state == DONE;
  assign d.wb_data = wb_data;
  assign d.wb_rd_addr = wb_rd_addr;
  assign d.wb_tag = wb_tag;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      quot <= '0;
      rem_q <= '0;
      dvs <= '0;
      op_rem <= 1'b0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      wb_data <= '0;
      wb_rd_addr <= '0;
      wb_tag <= '0;
    end else if (d.flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (d.div_valid) begin
          op_rem <= d.div_rem;
          q_neg <= s1 ^ s2;
          r_neg <= s1;
          quot <= a1;
          rem_q <= '0;
          dvs <= a2;
          cnt <= CNT_MAX;
          wb_rd_addr <= d.div_rd_addr;
          wb_tag <= d.div_tag;
          if (dz || ovf) begin
            wb_data <= dz ? (d.div_rem ? d.div_rs1 : '1) : (d.div_rem ? '0 : d.div_rs1);
            state <= DONE;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          quot <= {quot[XLEN-2:0], ge};
          rem_q <= ge ? sub : r_sh[XLEN-1:0];
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          wb_data <= op_rem ? r_fix : q_fix;
          state <= DONE;
        end
        default: if (d.wb_ready) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exu_div.sv
// tb_exu_div: directed self-checking bench for exu_div
module tb_exu_div;
  logic clk = 1'b0;
  logic rst;
  int n_chk = 0;
  int n_pass = 0;
  exu_div_if #(.XLEN(32), .TAG_W(4)) d ();
  exu_div #(.XLEN(32), .TAG_W(4)) u_dut (.clk(clk), .rst(rst), .d(d));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic r, input logic u, input logic [4:0] rd, input logic [3:0] tg);
    d.div_valid = 1'b1;
    d.div_rs1 = a;
    d.div_rs2 = b;
    d.div_rem = r;
    d.div_unsign = u;
    d.div_rd_addr = rd;
    d.div_tag = tg;
  endtask
  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b, input logic r, input logic u, input logic [4:0] rd, input logic [3:0] tg, input logic [31:0] exp, input int lat);
    int cyc;
    logic bad;
    drive(a, b, r, u, rd, tg);
    @(negedge clk);
    d.div_valid = 1'b0;
    cyc = 1;
    bad = 1'b0;
    while (!d.wb_valid && cyc < 100) begin
      if (!d.div_busy) bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_lat"}, 32'(cyc), 32'(lat));
    chk({nm, "_busy"}, {31'd0, bad}, 32'd0);
    chk({nm, "_data"}, d.wb_data, exp);
    chk({nm, "_rd"}, {27'd0, d.wb_rd_addr}, {27'd0, rd});
    chk({nm, "_tag"}, {28'd0, d.wb_tag}, {28'd0, tg});
    d.wb_ready = 1'b1;
    @(negedge clk);
    d.wb_ready = 1'b0;
    chk({nm, "_idle"}, {30'd0, d.wb_valid, d.div_busy}, 32'd0);
  endtask
  initial begin
    rst = 1'b1;
    d.flush = 1'b0;
    d.wb_ready = 1'b0;
    drive(32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 4'd0);
    d.div_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, d.div_busy}, 32'd0);
    chk("rst_valid", {31'd0, d.wb_valid}, 32'd0);
    chk("rst_data", d.wb_data, 32'd0);
    chk("rst_rd", {27'd0, d.wb_rd_addr}, 32'd0);
    chk("rst_tag", {28'd0, d.wb_tag}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_op("div_100_7", 32'd100, 32'd7, 1'b0, 1'b0, 5'd3, 4'd1, 32'd14, 34);
    run_op("rem_100_7", 32'd100, 32'd7, 1'b1, 1'b0, 5'd4, 4'd2, 32'd2, 34);
    run_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 5'd5, 4'd3, 32'hFFFF_FFFD, 34);
    run_op("rem_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 5'd6, 4'd4, 32'hFFFF_FFFF, 34);
    run_op("divu_max_2", 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1, 5'd7, 4'd5, 32'h7FFF_FFFF, 34);
    run_op("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 5'd8, 4'd6, 32'hFFFF_FFFD, 34);
    run_op("rem_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 5'd9, 4'd7, 32'd1, 34);
    run_op("rem_m8_3", 32'hFFFF_FFF8, 32'd3, 1'b1, 1'b0, 5'd0, 4'd8, 32'hFFFF_FFFE, 34);
    run_op("div_dz", 32'h1234, 32'd0, 1'b0, 1'b0, 5'd10, 4'd9, 32'hFFFF_FFFF, 1);
    run_op("divu_dz", 32'h1234, 32'd0, 1'b0, 1'b1, 5'd11, 4'd10, 32'hFFFF_FFFF, 1);
    run_op("rem_dz", 32'h1234, 32'd0, 1'b1, 1'b0, 5'd12, 4'd11, 32'h1234, 1);
    run_op("rem_dz_neg", 32'hFFFF_FFFB, 32'd0, 1'b1, 1'b0, 5'd13, 4'd12, 32'hFFFF_FFFB, 1);
    run_op("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd14, 4'd13, 32'h8000_0000, 1);
    run_op("rem_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd15, 4'd14, 32'd0, 1);
    run_op("divu_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd16, 4'd15, 32'd0, 34);
    run_op("remu_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd17, 4'd0, 32'h8000_0000, 34);
    drive(32'd100, 32'd7, 1'b0, 1'b0, 5'd20, 4'd5);
    @(negedge clk);
    d.div_valid = 1'b0;
    for (int i = 0; i < 40 && !d.wb_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, d.wb_valid}, 32'd1);
      chk("bp_busy", {31'd0, d.div_busy}, 32'd1);
      chk("bp_data", d.wb_data, 32'd14);
      chk("bp_tag", {28'd0, d.wb_tag}, 32'd5);
      chk("bp_rd", {27'd0, d.wb_rd_addr}, 32'd20);
      if (i == 1) drive(32'd50, 32'd0, 1'b1, 1'b0, 5'd21, 4'd6);
      @(negedge clk);
      d.div_valid = 1'b0;
    end
    d.wb_ready = 1'b1;
    @(negedge clk);
    d.wb_ready = 1'b0;
    chk("bp_done", {30'd0, d.wb_valid, d.div_busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("bp_ignored", {30'd0, d.wb_valid, d.div_busy}, 32'd0);
    drive(32'd1000, 32'd3, 1'b0, 1'b0, 5'd22, 4'd7);
    @(negedge clk);
    d.div_valid = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 9; i++) begin
        if (d.wb_valid) seen = 1'b1;
        @(negedge clk);
      end
      d.flush = 1'b1;
      @(negedge clk);
      d.flush = 1'b0;
      chk("fl_idle", {30'd0, d.wb_valid, d.div_busy}, 32'd0);
      chk("fl_noresult", {31'd0, seen}, 32'd0);
    end
    run_op("b2b", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 5'd23, 4'd9, 32'hFFFF_FFFD, 34);
    drive(32'd9, 32'd3, 1'b0, 1'b0, 5'd24, 4'd1);
    d.flush = 1'b1;
    @(negedge clk);
    d.flush = 1'b0;
    d.div_valid = 1'b0;
    chk("fl_vs_valid", {30'd0, d.wb_valid, d.div_busy}, 32'd0);
    drive(32'd9, 32'd0, 1'b0, 1'b0, 5'd25, 4'd2);
    @(negedge clk);
    d.div_valid = 1'b0;
    chk("fl_done_pre", {31'd0, d.wb_valid}, 32'd1);
    d.flush = 1'b1;
    @(negedge clk);
    d.flush = 1'b0;
    chk("fl_done", {30'd0, d.wb_valid, d.div_busy}, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
